// File: rtl/modulo_varredura_teclado_pkg.sv
// Shared constants and types for the 5x7 key-matrix scanner.
package modulo_varredura_teclado_pkg;

   localparam int unsigned KB_COL_W  = 3;
   localparam int unsigned KB_ROW_W  = 3;
   localparam int unsigned KB_CODE_W = 6;
   localparam int unsigned KB_N_COLS = 5;
   localparam int unsigned KB_N_ROWS = 7;
   localparam int unsigned KB_CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } kb_state_e;

   typedef enum logic [1:0] {
      FR_NONE   = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } kb_frame_e;

   typedef struct packed {
      logic                count_is_zero;
      logic                count_is_one;
      logic                count_gt_one;
      logic [KB_ROW_W-1:0] row;
   } kb_row_enc_t;

endpackage

// File: rtl/modulo_varredura_teclado_if.sv
// Scan tick, row sense, column drive and key event bundle.
interface modulo_varredura_teclado_if;
   import modulo_varredura_teclado_pkg::*;

   logic                 scan_en;
   logic [KB_N_ROWS-1:0] row_in;
   logic [KB_N_COLS-1:0] col_out;
   logic [KB_CODE_W-1:0] key_code;
   logic                 key_valid;
   logic                 key_held;
   logic                 multi_err;

   modport master (
      input  scan_en, row_in,
      output col_out, key_code, key_valid, key_held, multi_err
   );

   modport slave (
      output scan_en, row_in,
      input  col_out, key_code, key_valid, key_held, multi_err
   );

endinterface

// File: rtl/modulo_codificador_linha_7.sv
// Priority encoder over 7 active-high row closures: lowest closed row plus count class.
module modulo_codificador_linha_7
   import modulo_varredura_teclado_pkg::*;
(
   input  logic [KB_N_ROWS-1:0] closed_i,
   output kb_row_enc_t          enc_o
);

   logic [2:0]          cnt;
   logic [KB_ROW_W-1:0] row;

   always_comb begin
      cnt = 3'd0;
      row = '0;
      for (int i = 0; i < int'(KB_N_ROWS); i++) begin
         if (closed_i[i]) begin
            if (cnt == 3'd0) row = KB_ROW_W'(i);
            cnt = cnt + 3'd1;
         end
      end
      enc_o.count_is_zero = (cnt == 3'd0);
      enc_o.count_is_one  = (cnt == 3'd1);
      enc_o.count_gt_one  = (cnt > 3'd1);
      enc_o.row           = row;
   end

endmodule

// File: rtl/modulo_varredura_teclado.sv
// 5x7 key-matrix column scanner with frame-level debounce of press and release.
module modulo_varredura_teclado
   import modulo_varredura_teclado_pkg::*;
#(
   parameter int unsigned N_COLS     = KB_N_COLS,
   parameter int unsigned N_ROWS     = KB_N_ROWS,
   parameter int unsigned DEB_FRAMES = 4
)(
   input  logic                   clk,
   input  logic                   clr,
   modulo_varredura_teclado_if.master kb
);

   kb_state_e            state_q, state_d;
   kb_frame_e            acc_res_q, acc_res_d, frame_res;
   logic [KB_COL_W-1:0]  col_q, col_d;
   logic [KB_N_COLS-1:0] col_out_q, col_out_d;
   logic [KB_CODE_W-1:0] acc_code_q, acc_code_d, frame_code;
   logic [KB_CODE_W-1:0] cand_q, cand_d, key_code_q, key_code_d;
   logic [KB_CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic                 key_valid_q, key_valid_d, key_held_q, key_held_d;
   logic                 multi_err_q, multi_err_d;
   logic                 armed_q;
   logic                 tick, frame_close, deb_done;
   logic [KB_N_ROWS-1:0] closed;
   kb_row_enc_t          enc;

   assign closed = ~kb.row_in[N_ROWS-1:0];

   modulo_codificador_linha_7 u_enc (
      .closed_i (closed),
      .enc_o    (enc)
   );

   // A tick arriving on the first edge after reset release is dropped.
   assign tick        = kb.scan_en && armed_q;
   assign frame_close = tick && (col_q == KB_COL_W'(N_COLS - 1));
   assign cnt_inc     = cnt_q + KB_CNT_W'(1);
   assign deb_done    = (cnt_inc == KB_CNT_W'(DEB_FRAMES));

   // Frame result including the sample being taken this cycle.
   always_comb begin
      frame_res  = acc_res_q;
      frame_code = acc_code_q;
      if (enc.count_gt_one) begin
         frame_res = FR_MULTI;
      end else if (enc.count_is_one) begin
         if (acc_res_q == FR_NONE) begin
            frame_res  = FR_SINGLE;
            frame_code = {col_q, enc.row};
         end else begin
            frame_res = FR_MULTI;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      col_out_d   = col_out_q;
      acc_res_d   = acc_res_q;
      acc_code_d  = acc_code_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;
      key_valid_d = 1'b0;
      multi_err_d = 1'b0;

      if (tick) begin
         if (frame_close) begin
            col_d      = '0;
            acc_res_d  = FR_NONE;
            acc_code_d = '0;
         end else begin
            col_d      = col_q + KB_COL_W'(1);
            acc_res_d  = frame_res;
            acc_code_d = frame_code;
         end
         col_out_d = ~(KB_N_COLS'(1) << col_d);
      end

      if (frame_close) begin
         unique case (state_q)
            ST_IDLE: begin
               if (frame_res == FR_SINGLE) begin
                  if (DEB_FRAMES == 1) begin
                     state_d     = ST_PRESSED;
                     key_code_d  = frame_code;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                  end else begin
                     state_d = ST_DEBOUNCE;
                     cand_d  = frame_code;
                     cnt_d   = KB_CNT_W'(1);
                  end
               end else if (frame_res == FR_MULTI) begin
                  multi_err_d = 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (frame_res == FR_SINGLE) begin
                  if (frame_code != cand_q) begin
                     cand_d = frame_code;
                     cnt_d  = KB_CNT_W'(1);
                  end else if (deb_done) begin
                     state_d     = ST_PRESSED;
                     cnt_d       = '0;
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d     = ST_IDLE;
                  cnt_d       = '0;
                  multi_err_d = (frame_res == FR_MULTI);
               end
            end
            ST_PRESSED: begin
               if (frame_res == FR_NONE) begin
                  if (DEB_FRAMES == 1) begin
                     state_d    = ST_IDLE;
                     key_held_d = 1'b0;
                  end else begin
                     state_d = ST_RELEASE;
                     cnt_d   = KB_CNT_W'(1);
                  end
               end
            end
            default: begin
               if (frame_res != FR_NONE) begin
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
               end else if (deb_done) begin
                  state_d    = ST_IDLE;
                  cnt_d      = '0;
                  key_held_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         col_out_q   <= ~KB_N_COLS'(1);
         acc_res_q   <= FR_NONE;
         acc_code_q  <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         multi_err_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         col_out_q   <= col_out_d;
         acc_res_q   <= acc_res_d;
         acc_code_q  <= acc_code_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         multi_err_q <= multi_err_d;
         armed_q     <= 1'b1;
      end
   end

   assign kb.col_out   = col_out_q;
   assign kb.key_code  = key_code_q;
   assign kb.key_valid = key_valid_q;
   assign kb.key_held  = key_held_q;
   assign kb.multi_err = multi_err_q;

endmodule

// File: tb/tb_modulo_varredura_teclado.sv
// Scoreboard bench for the key-matrix scanner: a key model drives rows from col_out.
module tb_modulo_varredura_teclado;

   logic clk;
   logic clr;
   logic [34:0] keys;
   logic [6:0]  rows_n;
   logic [7:0]  evt;
   logic [7:0]  exp_evt;
   logic [7:0]  sb[$];
   int          n_vec;
   int          n_miss;
   int          valid_seen;
   int          base;

   modulo_varredura_teclado_if kb_if ();

   modulo_varredura_teclado #(.DEB_FRAMES(4)) dut (
      .clk (clk),
      .clr (clr),
      .kb  (kb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix model: a closed key pulls its row low while its column is driven.
   always_comb begin
      rows_n = 7'h7f;
      for (int c = 0; c < 5; c++)
         for (int r = 0; r < 7; r++)
            if (keys[c*7+r] && !kb_if.col_out[c]) rows_n[r] = 1'b0;
      kb_if.row_in = rows_n;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) kb_if.scan_en = 1'b1;
         @(negedge clk) kb_if.scan_en = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic frames(input int n);
      tick_n(5 * n);
   endtask

   task automatic set_key(input int c, input int r, input logic v);
      keys[c*7+r] = v;
   endtask

   // Event monitor: every pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (clr && (kb_if.key_valid || kb_if.multi_err)) begin
         evt = {kb_if.key_valid, kb_if.multi_err, kb_if.key_valid ? kb_if.key_code : 6'd0};
         if (kb_if.key_valid) valid_seen++;
         if (sb.size() == 0) begin
            check_eq("sb_extra", 32'(evt), 32'd0);
         end else begin
            exp_evt = sb.pop_front();
            check_eq("sb_event", 32'(evt), 32'(exp_evt));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] exp_col;
      n_vec = 0; n_miss = 0; valid_seen = 0;
      keys = '0;
      kb_if.scan_en = 1'b0;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_col_out", 32'(kb_if.col_out), 32'h1e);
      check_eq("rst_key_code", 32'(kb_if.key_code), 32'd0);
      check_eq("rst_key_valid", 32'(kb_if.key_valid), 32'd0);
      check_eq("rst_key_held", 32'(kb_if.key_held), 32'd0);
      check_eq("rst_multi_err", 32'(kb_if.multi_err), 32'd0);

      // Tick coincident with reset release is ignored.
      clr = 1'b1;
      kb_if.scan_en = 1'b1;
      @(negedge clk) kb_if.scan_en = 1'b0;
      check_eq("release_tick_ignored", 32'(kb_if.col_out), 32'h1e);

      for (int i = 1; i <= 5; i++) begin
         tick_n(1);
         exp_col = ~(5'd1 << (i % 5));
         check_eq("idle_col_seq", 32'(kb_if.col_out), 32'(exp_col));
      end
      repeat (20) @(negedge clk);
      check_eq("static_col_out", 32'(kb_if.col_out), 32'h1e);
      check_eq("idle_no_valid", 32'(valid_seen), 32'd0);

      // Clean press col 2 / row 5 with exact latency.
      set_key(2, 5, 1'b1);
      sb.push_back({2'b10, 6'b010_101});
      frames(3);
      tick_n(4);
      check_eq("press_not_early", 32'(valid_seen), 32'd0);
      tick_n(1);
      check_eq("press_accept", 32'(valid_seen), 32'd1);
      check_eq("press_code", 32'(kb_if.key_code), 32'h15);
      check_eq("press_held", 32'(kb_if.key_held), 32'd1);
      set_key(2, 5, 1'b0);
      frames(3);
      check_eq("release_still_held", 32'(kb_if.key_held), 32'd1);
      frames(1);
      check_eq("release_done", 32'(kb_if.key_held), 32'd0);

      // Bounce on col 1 / row 0, accepted on the 4th stable frame.
      set_key(1, 0, 1'b1);
      frames(2);
      set_key(1, 0, 1'b0);
      frames(1);
      set_key(1, 0, 1'b1);
      sb.push_back({2'b10, 6'b001_000});
      frames(3);
      check_eq("bounce_not_early", 32'(valid_seen), 32'd1);
      frames(1);
      check_eq("bounce_accept", 32'(valid_seen), 32'd2);
      check_eq("bounce_code", 32'(kb_if.key_code), 32'h08);
      set_key(1, 0, 1'b0);
      frames(4);
      check_eq("bounce_released", 32'(kb_if.key_held), 32'd0);

      // Two keys from IDLE: an error per frame, no accept.
      set_key(0, 3, 1'b1);
      set_key(4, 6, 1'b1);
      for (int i = 0; i < 3; i++) sb.push_back({2'b01, 6'd0});
      frames(3);
      check_eq("multi_no_valid", 32'(valid_seen), 32'd2);
      check_eq("multi_code_kept", 32'(kb_if.key_code), 32'h08);
      check_eq("multi_not_held", 32'(kb_if.key_held), 32'd0);
      set_key(0, 3, 1'b0);
      set_key(4, 6, 1'b0);
      frames(1);

      // Short release while pressed on (3,2) does not re-accept.
      set_key(3, 2, 1'b1);
      sb.push_back({2'b10, 6'b011_010});
      frames(4);
      check_eq("p5_accept", 32'(valid_seen), 32'd3);
      set_key(3, 2, 1'b0);
      frames(2);
      check_eq("p5_held_during_gap", 32'(kb_if.key_held), 32'd1);
      set_key(3, 2, 1'b1);
      frames(2);
      check_eq("p5_held_after_repress", 32'(kb_if.key_held), 32'd1);
      check_eq("p5_no_second_valid", 32'(valid_seen), 32'd3);
      set_key(3, 2, 1'b0);
      frames(4);
      check_eq("p5_released", 32'(kb_if.key_held), 32'd0);

      // Reset in mid-debounce discards partial state.
      set_key(0, 1, 1'b1);
      frames(3);
      tick_n(2);
      @(negedge clk) clr = 1'b0;
      #1;
      check_eq("midrst_col_out", 32'(kb_if.col_out), 32'h1e);
      check_eq("midrst_key_code", 32'(kb_if.key_code), 32'd0);
      check_eq("midrst_key_held", 32'(kb_if.key_held), 32'd0);
      check_eq("midrst_pulses", 32'({kb_if.key_valid, kb_if.multi_err}), 32'd0);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      base = valid_seen;
      sb.push_back({2'b10, 6'b000_001});
      frames(3);
      check_eq("post_rst_not_early", 32'(valid_seen), 32'(base));
      frames(1);
      check_eq("post_rst_accept", 32'(valid_seen), 32'(base + 1));
      check_eq("post_rst_code", 32'(kb_if.key_code), 32'h01);
      set_key(0, 1, 1'b0);
      frames(4);
      check_eq("post_rst_released", 32'(kb_if.key_held), 32'd0);

      repeat (4) @(negedge clk);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/modulo_varredura_teclado.md
Name: modulo_varredura_teclado

Overview:
- Scans a 5-column x 7-row key matrix laid over the 5x7 board and produces debounced attack coordinates plus a confirm strobe.
- This is the input-direction counterpart of the LED-matrix column scan: the column drive is the same, but rows are read instead of driven.
- `key_code` uses the same packing as the top level's `at_in`: `[5:3]` = column, `[2:0]` = row. It feeds `modulo_coord_coluna`, `modulo_coord_linha` and `modulo_dmx_mx_35_sel` without remapping.
- Advances on a one-cycle `scan_en` tick taken from `modulo_divisor_frequencia`.

Parameters:
- N_COLS, 5, number of scanned columns (fixed to 5 for this board; `col_out` width follows it).
- N_ROWS, 7, number of row inputs.
- DEB_FRAMES, 4, consecutive identical full frames required to accept a press or a release (range 1..15).

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-low reset.
- scan_en  in  1  one-clk tick; one column is sampled and advanced per tick.
- row_in  in  7  row sense lines, active-low (0 = key closed on the driven column); already synchronised externally.
- col_out  out  5  column drive, one-cold, active-low.
- key_code  out  6  `{col[2:0], row[2:0]}` of the accepted key; holds its value until the next accept.
- key_valid  out  1  one-clk pulse when a press is accepted.
- key_held  out  1  high while the accepted key is considered pressed.
- multi_err  out  1  one-clk pulse when a frame containing more than one closed key aborts a pending press.

Behaviour:
- Reset (`clr`=0, async):
  - column index = 0, `col_out` = 5'b11110.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `multi_err` = 0.
  - FSM = IDLE, frame accumulator cleared, debounce counter = 0.
- Scan, on each `scan_en` tick:
  - sample `row_in` for the current column into the frame accumulator;
  - then advance the column index, wrapping 4 -> 0, and update `col_out` in the same cycle.
- Column timing:
  - `col_out` changes only on `scan_en` cycles.
  - Each column is therefore driven for a full tick period before it is sampled.
- Frame:
  - a frame closes on the tick that samples column 4;
  - a frame contains exactly 5 samples.
  - Frame result is one of: NONE (no closed key), SINGLE(code) (exactly one closed key), MULTI (two or more, including two rows on one column).
  - The accumulator clears when the frame closes.
- Row encoding: `row_in[0]` = row 0 … `row_in[6]` = row 6. Column index 0..4 comes from the scan position, so code values are 0..4 in `[5:3]` and 0..6 in `[2:0]`.
- FSM (transitions are evaluated only at frame close):
  - IDLE:
    - SINGLE(c) -> DEBOUNCE, with cand = c and cnt = 1.
    - NONE -> stay in IDLE.
    - MULTI -> stay in IDLE, pulse `multi_err`.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1.
    - When cnt reaches DEB_FRAMES -> PRESSED: `key_code` = cand, `key_valid` pulses, `key_held` = 1.
    - SINGLE(other) -> restart with cand = other and cnt = 1.
    - NONE -> IDLE.
    - MULTI -> IDLE, pulse `multi_err`.
  - PRESSED:
    - NONE -> RELEASE with cnt = 1.
    - SINGLE(any) or MULTI -> stay in PRESSED; no new accept and no error.
  - RELEASE:
    - NONE -> cnt+1; when cnt reaches DEB_FRAMES -> IDLE and `key_held` = 0.
    - Anything else -> PRESSED, cnt = 0; no second `key_valid`.
- DEB_FRAMES = 1: entry into DEBOUNCE accepts immediately. Go straight IDLE -> PRESSED on that frame close, and PRESSED -> IDLE on the first NONE frame.
- Latency:
  - `key_valid` is registered and asserted the clk after the `scan_en` tick that closes the accepting frame.
  - A press that is stable from a frame start is accepted after exactly DEB_FRAMES frames, i.e. 5*DEB_FRAMES ticks.
- Simultaneous events:
  - `multi_err` and `key_valid` can never pulse in the same cycle.
  - A `scan_en` in the cycle `clr` releases is ignored; scanning starts on the next tick.
- Reset mid-frame or mid-debounce discards all partial state; no pulse is emitted.
- If `scan_en` stays low, all state holds and the outputs are static.

Decomposition:
- Shared package constants:
  - KB_COL_W = 3, KB_ROW_W = 3, KB_CODE_W = 6;
  - FSM state encoding (IDLE = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3).
- One sub-module: `modulo_codificador_linha_7`, a combinational priority encoder from 7 rows to {count_is_zero, count_is_one, count_gt_one, row[2:0]}. It is used per sample to update the frame accumulator.

Test Plan:
- Reset, then idle at DEB_FRAMES=4 -> `col_out` cycles 11110, 11101, 11011, 10111, 01111, 11110 on successive ticks; no pulses.
- Hold column 2 / row 5 (`row_in[5]`=0 while `col_out`[2]=0) for 4 frames -> `key_valid` pulses once, `key_code` = 6'b010_101, `key_held` = 1; after release and 4 empty frames `key_held` = 0.
- Bounce: press col 1 / row 0 for 2 frames, release 1 frame, then hold 4 frames -> exactly one `key_valid`, `key_code` = 6'b001_000, accepted on the 4th stable frame.
- Two keys, col 0 row 3 and col 4 row 6, closed together from IDLE -> `multi_err` pulses every frame, no `key_valid`, `key_code` unchanged.
- While PRESSED on (3,2), release for 2 frames then repress -> no second `key_valid`, `key_held` stays 1.
- Assert `clr`=0 mid-debounce (cnt=3) -> all outputs 0, `col_out` = 11110; a subsequent 4-frame hold accepts normally.
